// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired Moore control unit for the bus-based datapath. It steps the
//   fetch (T0-T2), decode (T3) and execute (T4-T8) sequence for ld, ldi, st
//   and addi. It adds a memory-ready handshake with a stall timeout, run/halt
//   control, illegal-opcode trapping and a saturating retired-instruction
//   counter.
//
// Ports
//   clock        in   system clock, rising-edge active
//   clear        in   asynchronous active-low reset
//   run          in   1 = keep fetching; 0 = halt once the current instruction retires
//   ir           in   instruction register (opcode sampled at T3 only)
//   mem_ready    in   memory finished the current Read/Write (sampled in wait steps only)
//   PCout..ADD   out  datapath control strobes, decoded from state only
//   present_step out  0-8 = T0-T8, 14 = IDLE, 15 = FAULT
//   illegal_op   out  one-cycle pulse in the cycle after T3 decoded an undefined opcode
//   mem_fault    out  sticky flag, set when a wait step times out
//   instr_count  out  retired instructions, saturating at all-ones
module control_sequencer #(
  parameter int                      IR_W       = 32,
  parameter int                      OP_MSB     = 31,
  parameter int                      OP_LSB     = 27,
  parameter logic [OP_MSB-OP_LSB:0]  OP_LD      = 5'b00000,
  parameter logic [OP_MSB-OP_LSB:0]  OP_LDI     = 5'b00001,
  parameter logic [OP_MSB-OP_LSB:0]  OP_ST      = 5'b00010,
  parameter logic [OP_MSB-OP_LSB:0]  OP_ADDI    = 5'b01011,
  parameter int                      WAIT_LIMIT = 15,
  parameter int                      CNT_W      = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [IR_W-1:0]  ir,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zlowin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             Read,
  output logic             Write,
  output logic             MD_read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Grb,
  output logic             Gra,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             Csignout,
  output logic             ADD,
  output logic [3:0]       present_step,
  output logic             illegal_op,
  output logic             mem_fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT_C = WCNT_W'(WAIT_LIMIT);

  // Encodings double as the externally visible step number.
  typedef enum logic [3:0] {
    S_T0    = 4'd0,
    S_T1    = 4'd1,
    S_T2    = 4'd2,
    S_T3    = 4'd3,
    S_T4    = 4'd4,
    S_T5    = 4'd5,
    S_T6    = 4'd6,
    S_T7    = 4'd7,
    S_T8    = 4'd8,
    S_IDLE  = 4'd14,
    S_FAULT = 4'd15
  } state_t;

  // Instruction class latched at T3 so later ir changes cannot disturb execute.
  typedef enum logic [1:0] {
    OPC_LD   = 2'd0,
    OPC_LDI  = 2'd1,
    OPC_ST   = 2'd2,
    OPC_ADDI = 2'd3
  } opc_t;

  state_t             state_q, state_d;
  opc_t               op_q, op_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               mem_fault_q, mem_fault_d;
  logic               illegal_q, illegal_d;

  logic [OP_MSB-OP_LSB:0] opcode;
  logic [WCNT_W-1:0]      wait_inc;
  logic                   in_wait;
  logic                   stall;
  logic                   retire;
  state_t                 fetch_next;

  // Only the opcode field of ir is decoded; fold the rest so it is not flagged unused.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir;

  assign opcode   = ir[OP_MSB:OP_LSB];
  assign wait_inc = wait_cnt_q + 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Memory handshake steps: T1 for every fetch, T7 for ld reads, T8 for st writes.
  always_comb begin
    in_wait = 1'b0;
    case (state_q)
      S_T1:    in_wait = 1'b1;
      S_T7:    in_wait = (op_q == OPC_LD);
      S_T8:    in_wait = (op_q == OPC_ST);
      default: in_wait = 1'b0;
    endcase
  end

  assign stall = in_wait && !mem_ready;

  // ---------------- next-state ----------------
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    wait_cnt_d    = wait_cnt_q;
    instr_count_d = instr_count_q;
    mem_fault_d   = mem_fault_q;
    illegal_d     = 1'b0;
    retire        = 1'b0;
    fetch_next    = run ? S_T0 : S_IDLE;

    if (stall) begin
      // Hold the step; the stall that brings the count to the limit is fatal.
      wait_cnt_d = wait_inc;
      if (wait_inc == WAIT_LIMIT_C) begin
        state_d     = S_FAULT;
        mem_fault_d = 1'b1;
      end
    end else begin
      if (in_wait) begin
        wait_cnt_d = '0;
      end
      case (state_q)
        S_IDLE: if (run) state_d = S_T0;
        S_T0:   state_d = S_T1;
        S_T1:   state_d = S_T2;
        S_T2:   state_d = S_T3;
        S_T3: begin
          if (opcode == OP_LD) begin
            op_d    = OPC_LD;
            state_d = S_T4;
          end else if (opcode == OP_LDI) begin
            op_d    = OPC_LDI;
            state_d = S_T4;
          end else if (opcode == OP_ST) begin
            op_d    = OPC_ST;
            state_d = S_T4;
          end else if (opcode == OP_ADDI) begin
            op_d    = OPC_ADDI;
            state_d = S_T4;
          end else begin
            // Trap: no retire, straight to the next-fetch decision.
            illegal_d = 1'b1;
            state_d   = fetch_next;
          end
        end
        S_T4:   state_d = S_T5;
        S_T5:   state_d = S_T6;
        S_T6: begin
          if (op_q == OPC_LD || op_q == OPC_ST) begin
            state_d = S_T7;
          end else begin
            retire = 1'b1;
          end
        end
        S_T7:    state_d = S_T8;
        S_T8:    retire  = 1'b1;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
      if (retire) begin
        state_d       = fetch_next;
        instr_count_d = sat_inc(instr_count_q);
      end
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q       <= S_IDLE;
      op_q          <= OPC_LDI;
      wait_cnt_q    <= '0;
      instr_count_q <= '0;
      mem_fault_q   <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_count_q <= instr_count_d;
      mem_fault_q   <= mem_fault_d;
      illegal_q     <= illegal_d;
    end
  end

  // ---------------- output decode ----------------
  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zlowin   = 1'b0;
    Zlowout  = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    MD_read  = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Grb      = 1'b0;
    Gra      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    BAout    = 1'b0;
    Csignout = 1'b0;
    ADD      = 1'b0;
    case (state_q)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MD_read = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T4: begin
        // Base operand: addi reads rb itself, the others use base-address gating.
        Grb = 1'b1;
        Yin = 1'b1;
        if (op_q == OPC_ADDI) begin
          Rout = 1'b1;
        end else begin
          BAout = 1'b1;
        end
      end
      S_T5: begin
        Csignout = 1'b1;
        ADD      = 1'b1;
        Zlowin   = 1'b1;
      end
      S_T6: begin
        Zlowout = 1'b1;
        if (op_q == OPC_LD || op_q == OPC_ST) begin
          MARin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      S_T7: begin
        MDRin = 1'b1;
        if (op_q == OPC_ST) begin
          Gra  = 1'b1;
          Rout = 1'b1;
        end else begin
          Read    = 1'b1;
          MD_read = 1'b1;
        end
      end
      S_T8: begin
        MDRout = 1'b1;
        if (op_q == OPC_ST) begin
          Write = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign present_step = state_q;
  assign illegal_op   = illegal_q;
  assign mem_fault    = mem_fault_q;
  assign instr_count  = instr_count_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, Write, MD_read, MDRin;
  logic MDRout, IRin, Yin, Grb, Gra, Rin, Rout, BAout, Csignout, ADD;
  logic [3:0]  present_step;
  logic        illegal_op;
  logic        mem_fault;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;

  // Control bit positions in the packed vector built by ctl().
  localparam logic [19:0] B_PCOUT = 20'h80000, B_MARIN = 20'h40000, B_INCPC = 20'h20000;
  localparam logic [19:0] B_ZLIN = 20'h10000, B_ZLOUT = 20'h08000, B_PCIN = 20'h04000;
  localparam logic [19:0] B_READ = 20'h02000, B_WRITE = 20'h01000, B_MDRD = 20'h00800;
  localparam logic [19:0] B_MDRIN = 20'h00400, B_MDROUT = 20'h00200, B_IRIN = 20'h00100;
  localparam logic [19:0] B_YIN = 20'h00080, B_GRB = 20'h00040, B_GRA = 20'h00020;
  localparam logic [19:0] B_RIN = 20'h00010, B_ROUT = 20'h00008, B_BAOUT = 20'h00004;
  localparam logic [19:0] B_CSIGN = 20'h00002, B_ADD = 20'h00001;

  localparam logic [19:0] E_T0     = B_PCOUT | B_MARIN | B_INCPC | B_ZLIN;
  localparam logic [19:0] E_T1     = B_ZLOUT | B_PCIN | B_READ | B_MDRD | B_MDRIN;
  localparam logic [19:0] E_T2     = B_MDROUT | B_IRIN;
  localparam logic [19:0] E_T4     = B_GRB | B_BAOUT | B_YIN;
  localparam logic [19:0] E_T4ADDI = B_GRB | B_ROUT | B_YIN;
  localparam logic [19:0] E_T5     = B_CSIGN | B_ADD | B_ZLIN;
  localparam logic [19:0] E_T6LDI  = B_ZLOUT | B_GRA | B_RIN;
  localparam logic [19:0] E_T6LD   = B_ZLOUT | B_MARIN;
  localparam logic [19:0] E_T7LD   = B_READ | B_MDRD | B_MDRIN;
  localparam logic [19:0] E_T8LD   = B_MDROUT | B_GRA | B_RIN;
  localparam logic [19:0] E_T7ST   = B_GRA | B_ROUT | B_MDRIN;
  localparam logic [19:0] E_T8ST   = B_MDROUT | B_WRITE;

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zlowin(Zlowin), .Zlowout(Zlowout),
    .PCin(PCin), .Read(Read), .Write(Write), .MD_read(MD_read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Grb(Grb), .Gra(Gra), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .Csignout(Csignout), .ADD(ADD),
    .present_step(present_step), .illegal_op(illegal_op), .mem_fault(mem_fault),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  function automatic logic [19:0] ctl();
    return {PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, Write, MD_read, MDRin,
            MDRout, IRin, Yin, Grb, Gra, Rin, Rout, BAout, Csignout, ADD};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; run = 1'b0; ir = '0; mem_ready = 1'b1;
    #12;
    checks++;
    if (present_step !== 4'd14) begin
      errors++; $display("FAIL reset_step: got %0d want 14", present_step);
    end
    checks++;
    if (ctl() !== 20'h0 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: got %h/%b want 0/0", ctl(), illegal_op);
    end
    checks++;
    if (instr_count !== 16'd0 || mem_fault !== 1'b0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%b want 0/0", instr_count, mem_fault);
    end
    @(negedge clock);
    clear = 1'b1;
    tick();
    checks++;
    if (present_step !== 4'd14) begin
      errors++; $display("FAIL idle_hold: got %0d want 14", present_step);
    end
  endtask

  task automatic test_ldi();
    logic [3:0]  es [8];
    logic [19:0] ec [8];
    es[0] = 0; es[1] = 1; es[2] = 2; es[3] = 3; es[4] = 4; es[5] = 5; es[6] = 6; es[7] = 0;
    ec[0] = E_T0; ec[1] = E_T1; ec[2] = E_T2; ec[3] = 20'h0;
    ec[4] = E_T4; ec[5] = E_T5; ec[6] = E_T6LDI; ec[7] = E_T0;
    run = 1'b1; mem_ready = 1'b1; ir = {5'b00001, 27'h0};
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (present_step !== es[i] || ctl() !== ec[i]) begin
        errors++;
        $display("FAIL ldi_step%0d: got step %0d ctl %h want step %0d ctl %h",
                 i, present_step, ctl(), es[i], ec[i]);
      end
      if (i == 6) begin
        checks++;
        if (instr_count !== 16'd0) begin
          errors++; $display("FAIL ldi_cnt_before: got %0d want 0", instr_count);
        end
      end
    end
    checks++;
    if (instr_count !== 16'd1) begin
      errors++; $display("FAIL ldi_cnt: got %0d want 1", instr_count);
    end
  endtask

  // Entered with the sequencer in T0.
  task automatic test_ld_wait();
    ir = {5'b00000, 27'h5a5};
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (present_step !== 4'd1 || ctl() !== E_T1) begin
        errors++;
        $display("FAIL ld_t1_hold%0d: got step %0d ctl %h want step 1 ctl %h",
                 i, present_step, ctl(), E_T1);
      end
    end
    mem_ready = 1'b1;
    tick(); // T2
    tick(); // T3
    tick(); // T4
    tick(); // T5
    tick(); // T6
    checks++;
    if (present_step !== 4'd6 || ctl() !== E_T6LD) begin
      errors++; $display("FAIL ld_t6: got step %0d ctl %h want 6 %h", present_step, ctl(), E_T6LD);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (present_step !== 4'd7 || ctl() !== E_T7LD) begin
        errors++;
        $display("FAIL ld_t7_hold%0d: got step %0d ctl %h want step 7 ctl %h",
                 i, present_step, ctl(), E_T7LD);
      end
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (present_step !== 4'd8 || ctl() !== E_T8LD || instr_count !== 16'd1) begin
      errors++;
      $display("FAIL ld_t8: got step %0d ctl %h cnt %0d want 8 %h 1",
               present_step, ctl(), instr_count, E_T8LD);
    end
    tick();
    checks++;
    if (present_step !== 4'd0 || instr_count !== 16'd2) begin
      errors++; $display("FAIL ld_retire: got step %0d cnt %0d want 0 2", present_step, instr_count);
    end
  endtask

  // Entered in T0 with run=1.
  task automatic test_st_halt();
    ir = {5'b00010, 27'h0};
    mem_ready = 1'b1;
    tick(); tick(); tick(); tick(); // T1 T2 T3 T4
    checks++;
    if (present_step !== 4'd4 || ctl() !== E_T4) begin
      errors++; $display("FAIL st_t4: got step %0d ctl %h want 4 %h", present_step, ctl(), E_T4);
    end
    tick(); // T5
    run = 1'b0;
    ir = {5'b11111, 27'h0};
    tick();
    checks++;
    if (present_step !== 4'd6 || ctl() !== E_T6LD) begin
      errors++; $display("FAIL st_t6: got step %0d ctl %h want 6 %h", present_step, ctl(), E_T6LD);
    end
    tick();
    checks++;
    if (present_step !== 4'd7 || ctl() !== E_T7ST) begin
      errors++; $display("FAIL st_t7: got step %0d ctl %h want 7 %h", present_step, ctl(), E_T7ST);
    end
    tick();
    checks++;
    if (present_step !== 4'd8 || ctl() !== E_T8ST) begin
      errors++; $display("FAIL st_t8: got step %0d ctl %h want 8 %h", present_step, ctl(), E_T8ST);
    end
    tick();
    checks++;
    if (present_step !== 4'd14 || instr_count !== 16'd3 || ctl() !== 20'h0) begin
      errors++;
      $display("FAIL st_idle: got step %0d cnt %0d ctl %h want 14 3 0",
               present_step, instr_count, ctl());
    end
    tick();
    checks++;
    if (present_step !== 4'd14) begin
      errors++; $display("FAIL st_idle_stay: got %0d want 14", present_step);
    end
  endtask

  // Entered in IDLE.
  task automatic test_illegal();
    run = 1'b1; mem_ready = 1'b1; ir = {5'b11111, 27'h0};
    tick(); tick(); tick(); tick(); // T0 T1 T2 T3
    checks++;
    if (present_step !== 4'd3 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL ill_t3: got step %0d ill %b want 3 0", present_step, illegal_op);
    end
    tick();
    checks++;
    if (present_step !== 4'd0 || illegal_op !== 1'b1 || instr_count !== 16'd3) begin
      errors++;
      $display("FAIL ill_pulse: got step %0d ill %b cnt %0d want 0 1 3",
               present_step, illegal_op, instr_count);
    end
    run = 1'b0;
    tick();
    checks++;
    if (present_step !== 4'd1 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL ill_clear: got step %0d ill %b want 1 0", present_step, illegal_op);
    end
    tick(); tick(); tick(); // T2 T3 -> IDLE
    checks++;
    if (present_step !== 4'd14 || illegal_op !== 1'b1 || instr_count !== 16'd3) begin
      errors++;
      $display("FAIL ill_halt: got step %0d ill %b cnt %0d want 14 1 3",
               present_step, illegal_op, instr_count);
    end
  endtask

  // Entered in IDLE.
  task automatic test_fault();
    run = 1'b1; mem_ready = 1'b0; ir = {5'b00001, 27'h0};
    tick(); // T0
    tick(); // T1
    for (int i = 1; i < 15; i++) begin
      tick();
      checks++;
      if (present_step !== 4'd1 || mem_fault !== 1'b0) begin
        errors++;
        $display("FAIL fault_stall%0d: got step %0d fault %b want 1 0", i, present_step, mem_fault);
      end
    end
    tick();
    checks++;
    if (present_step !== 4'd15 || mem_fault !== 1'b1 || ctl() !== 20'h0) begin
      errors++;
      $display("FAIL fault_enter: got step %0d fault %b ctl %h want 15 1 0",
               present_step, mem_fault, ctl());
    end
    mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if (present_step !== 4'd15 || mem_fault !== 1'b1 || instr_count !== 16'd3) begin
      errors++;
      $display("FAIL fault_stay: got step %0d fault %b cnt %0d want 15 1 3",
               present_step, mem_fault, instr_count);
    end
    run = 1'b0;
    clear = 1'b0;
    #2;
    checks++;
    if (present_step !== 4'd14 || mem_fault !== 1'b0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL fault_clear: got step %0d fault %b cnt %0d want 14 0 0",
               present_step, mem_fault, instr_count);
    end
    @(negedge clock);
    clear = 1'b1;
    tick();
  endtask

  // Entered in IDLE: one addi, then an ld aborted by clear at T6.
  task automatic test_clear_mid();
    run = 1'b1; mem_ready = 1'b1; ir = {5'b01011, 27'h0};
    tick(); tick(); tick(); tick(); tick(); // T0..T4
    checks++;
    if (present_step !== 4'd4 || ctl() !== E_T4ADDI) begin
      errors++; $display("FAIL addi_t4: got step %0d ctl %h want 4 %h", present_step, ctl(), E_T4ADDI);
    end
    tick(); tick(); // T5 T6
    checks++;
    if (present_step !== 4'd6 || ctl() !== E_T6LDI) begin
      errors++; $display("FAIL addi_t6: got step %0d ctl %h want 6 %h", present_step, ctl(), E_T6LDI);
    end
    ir = {5'b00000, 27'h0};
    tick(); // T0, addi retired
    checks++;
    if (present_step !== 4'd0 || instr_count !== 16'd1) begin
      errors++; $display("FAIL addi_retire: got step %0d cnt %0d want 0 1", present_step, instr_count);
    end
    for (int i = 0; i < 6; i++) tick(); // T1..T6
    checks++;
    if (present_step !== 4'd6 || ctl() !== E_T6LD) begin
      errors++; $display("FAIL clr_t6: got step %0d ctl %h want 6 %h", present_step, ctl(), E_T6LD);
    end
    #2;
    clear = 1'b0;
    #1;
    checks++;
    if (present_step !== 4'd14 || ctl() !== 20'h0 || instr_count !== 16'd0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL clr_async: got step %0d ctl %h cnt %0d ill %b want 14 0 0 0",
               present_step, ctl(), instr_count, illegal_op);
    end
    run = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    tick();
    checks++;
    if (present_step !== 4'd14 || instr_count !== 16'd0) begin
      errors++; $display("FAIL clr_after: got step %0d cnt %0d want 14 0", present_step, instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_ld_wait();
    test_st_halt();
    test_illegal();
    test_fault();
    test_clear_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit for the bus-based datapath.
- Replaces hand-driven testbench stimulus: it steps fetch (T0–T2), decode (T3) and execute (T4–T8) for ld, ldi, st and addi.
- Its outputs drive the datapath control inputs directly.
- Adds a memory-ready handshake with timeout, run/halt control, illegal-opcode trapping and a retired-instruction counter.

Parameters:
- IR_W, 32, instruction register width
- OP_MSB, 31, opcode field MSB within ir
- OP_LSB, 27, opcode field LSB within ir
- OP_LD, 5'b00000, load opcode
- OP_LDI, 5'b00001, load-immediate opcode
- OP_ST, 5'b00010, store opcode
- OP_ADDI, 5'b01011, add-immediate opcode
- WAIT_LIMIT, 15, maximum stall cycles in a memory step before fault
- CNT_W, 16, retired-instruction counter width

Ports:
- clock  in  1  system clock; all state changes on rising edge
- clear  in  1  asynchronous, active-low reset
- run  in  1  1 = fetch new instructions; 0 = halt after the current instruction retires
- ir  in  IR_W  instruction register contents, valid from T3 onward
- mem_ready  in  1  memory completed the current Read/Write this cycle
- PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, Write, MD_read, MDRin, MDRout, IRin, Yin, Grb, Gra, Rin, Rout, BAout, Csignout, ADD  out  1 each  datapath controls
- present_step  out  4  current step: 0–8 = T0–T8, 14 = IDLE, 15 = FAULT
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- mem_fault  out  1  sticky; set on handshake timeout
- instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset (clear=0, async):
  - state = IDLE, wait counter = 0, instr_count = 0, mem_fault = 0.
  - All control outputs and illegal_op = 0; present_step = 14.
  - Asserting clear mid-instruction aborts immediately, with no retire.
- IDLE: go to T0 when run=1; otherwise stay.
- All controls are decoded combinationally from state only. Unlisted signals are 0. Each step lasts one cycle except the wait steps (marked "wait").
- Fetch:
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1 (wait): Zlowout, PCin, Read, MD_read, MDRin.
  - T2: MDRout, IRin.
  - T3: no outputs; decode ir[OP_MSB:OP_LSB].
- ldi:
  - T4: Grb, BAout, Yin.
  - T5: Csignout, ADD, Zlowin.
  - T6: Zlowout, Gra, Rin; retire.
- addi: as ldi, except T4 is Grb, Rout, Yin (no BAout).
- ld:
  - T4, T5: as ldi.
  - T6: Zlowout, MARin.
  - T7 (wait): Read, MD_read, MDRin.
  - T8: MDRout, Gra, Rin; retire.
- st:
  - T4–T6: as ld.
  - T7: Gra, Rout, MDRin (MD_read=0).
  - T8 (wait): MDRout, Write; retire.
- Illegal opcode at T3: pulse illegal_op for one cycle, no retire, then next-fetch decision.
- Wait steps:
  - Outputs are held while mem_ready=0, and the wait counter increments each stalled cycle.
  - mem_ready=1 advances the step next edge and clears the counter; mem_ready is sampled only in wait steps.
  - If the counter reaches WAIT_LIMIT with mem_ready still 0: go to FAULT and set mem_fault.
  - FAULT: all controls 0, no retire; exit only via reset.
- Retire:
  - On leaving the final step, instr_count increments, saturating at all-ones.
  - Next state is T0 if run=1, else IDLE. The same decision applies after an illegal opcode.
  - run is sampled only at the retire/illegal edge. Deasserting run mid-instruction never truncates it.
- mem_ready=1 at T1 entry completes in one cycle (zero wait). The opcode is sampled only at T3; ir changes in other steps are ignored.

Test Plan:
- Reset, then run=1, mem_ready=1, ir opcode=00001 (ldi) → present_step 0,1,2,3,4,5,6,0.
  - T4 has Grb=BAout=Yin=1; T6 has Zlowout=Gra=Rin=1.
  - instr_count=1 after T6.
- ld with mem_ready held 0 for 3 cycles in T1 and 2 cycles in T7 → T1 lasts 4 cycles and T7 lasts 3, with outputs constant throughout.
  - T8 asserts MDRout=Gra=Rin=1; instr_count increments by 1.
- st, then run dropped to 0 during T5 → instruction completes.
  - T7 has Rout=MDRin=1; T8 has MDRout=Write=1.
  - Ends in IDLE (present_step=14), instr_count incremented.
- Opcode 11111 → illegal_op pulses one cycle after T3 → back to T0; instr_count unchanged.
- mem_ready=0 forever in T1 → after 15 stalled cycles, present_step=15, mem_fault=1, all controls 0.
  - Releasing clear low→high returns to IDLE with mem_fault=0.
- clear asserted during ld T6 → all outputs 0 immediately (asynchronous, no clock edge needed), instr_count=0, present_step=14.
